lcd_timing_gen: RTL

- Raster timing generator for the 480x272 RGB LCD, clocked by the 12 MHz pixel clock from the board PLL.
- Produces HSYNC/VSYNC/DE, the pixel coordinates and frame/line strobes consumed by the pong renderer and the LCD pin drivers.
- Stays quiet until the PLL reports lock and a settle interval has elapsed; drops back to quiet if lock is lost.

---
 rtl/lcd_timing_pkg.sv | 32 +++
 rtl/lcd_timing_gen_if.sv | 25 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/lcd_timing_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared constants, state encoding and coordinate widths for the 480x272 LCD raster.
// Imported by the timing generator, its interface and the consumers of its coordinates.
package lcd_timing_pkg;

  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 43;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 12;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 8;

  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int H_CNT_MAX = 1 << X_W;
  localparam int V_CNT_MAX = 1 << Y_W;

  function automatic int line_total(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

  localparam int DEF_H_TOTAL = line_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_V_TOTAL = line_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Raster timing bundle: PLL lock in, sync/DE/coordinates/strobes out.
// master = timing generator, slave = renderer and pin drivers (observe only).
interface lcd_timing_gen_if;
  import lcd_timing_pkg::*;

  logic           pll_lock;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [X_W-1:0] px_x;
  logic [Y_W-1:0] px_y;
  logic           line_start;
  logic           frame_start;
  logic           running;

  modport master (
    input  pll_lock,
    output hsync, vsync, de, px_x, px_y, line_start, frame_start, running
  );

  modport slave (
    input pll_lock, hsync, vsync, de, px_x, px_y, line_start, frame_start, running
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency, no flow control.
// Both stages clear to 0 on synchronous reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: waits for PLL lock plus a settle interval, then scans frames.
// Outputs are registered from the previous cycle's counters (1-clock latency); no backpressure.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BP          = DEF_H_BP,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_FP          = DEF_H_FP,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BP          = DEF_V_BP,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int V_FP          = DEF_V_FP,
  parameter bit SYNC_POL      = 1'b0,
  parameter int SETTLE_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  lcd_timing_gen_if.master bus
);

  localparam int H_TOTAL = line_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = line_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_SYNC_E  = X_W'(H_SYNC);
  localparam logic [X_W-1:0] H_ACT_BEG = X_W'(H_SYNC + H_BP);
  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_SYNC_E  = Y_W'(V_SYNC);
  localparam logic [Y_W-1:0] V_ACT_BEG = Y_W'(V_SYNC + V_BP);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  if (H_TOTAL > H_CNT_MAX || V_TOTAL > V_CNT_MAX || SETTLE_CYCLES < 1) begin : g_param_check
    $fatal(1, "lcd_timing_gen: raster totals exceed counter widths or settle interval is empty");
  end

  logic             w_lock_s;
  state_e           r_state, w_state_nxt;
  logic [X_W-1:0]   r_h_cnt, w_h_nxt;
  logic [Y_W-1:0]   r_v_cnt, w_v_nxt;
  logic [SET_W-1:0] r_settle_cnt, w_settle_nxt;

  logic           r_hsync, r_vsync, r_de, r_line_start, r_frame_start, r_running;
  logic [X_W-1:0] r_px_x;
  logic [Y_W-1:0] r_px_y;
  logic           w_h_act, w_v_act, w_run_ok;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.pll_lock),
    .o_q (w_lock_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= WAIT_LOCK;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_h_nxt      = r_h_cnt;
    w_v_nxt      = r_v_cnt;
    w_settle_nxt = r_settle_cnt;
    case (r_state)
      WAIT_LOCK: begin
        w_h_nxt      = '0;
        w_v_nxt      = '0;
        w_settle_nxt = '0;
        if (w_lock_s) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!w_lock_s) begin
          w_state_nxt  = WAIT_LOCK;
          w_settle_nxt = '0;
        end else if (r_settle_cnt == SET_LAST) begin
          w_state_nxt  = RUN;
          w_settle_nxt = '0;
          w_h_nxt      = '0;
          w_v_nxt      = '0;
        end else begin
          w_settle_nxt = r_settle_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_h_nxt     = '0;
          w_v_nxt     = '0;
        end else if (r_h_cnt == H_LAST) begin
          w_h_nxt = '0;
          w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
          w_h_nxt = r_h_cnt + 1'b1;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Gating on w_lock_s makes the outputs go quiet on the same edge the FSM leaves RUN.
  assign w_run_ok = (r_state == RUN) && w_lock_s;
  assign w_h_act  = (r_h_cnt >= H_ACT_BEG) && (r_h_cnt <= H_ACT_END);
  assign w_v_act  = (r_v_cnt >= V_ACT_BEG) && (r_v_cnt <= V_ACT_END);

  always_ff @(posedge clk) begin
    if (rst || !w_run_ok) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_de          <= 1'b0;
      r_px_x        <= '0;
      r_px_y        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_hsync       <= (r_h_cnt < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (r_v_cnt < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
      r_de          <= w_h_act && w_v_act;
      r_px_x        <= w_h_act ? (r_h_cnt - H_ACT_BEG) : '0;
      r_px_y        <= w_v_act ? (r_v_cnt - V_ACT_BEG) : '0;
      r_line_start  <= (r_h_cnt == '0);
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_running     <= 1'b1;
    end
  end

  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.de          = r_de;
  assign bus.px_x        = r_px_x;
  assign bus.px_y        = r_px_y;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.running     = r_running;

endmodule
